reg_cmd_engine: RTL and testbench
=================================

REG_CMD_ENGINE -- requirements
Module: reg_cmd_engine

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1000000, inter-byte timeout in clk_i cycles while a command is partly received.
REQ-002 SHALL have one clock and an asynchronous active-low reset: clk_i  in  1  sole clock, all logic rising-edge.
REQ-003 reset_i  in  1  asynchronous reset, active low; asserted at reset_i=0.
REQ-004 cmdfifo_rxf  in  1  one-cycle pulse, cmdfifo_din holds a received byte.
REQ-005 cmdfifo_din  in  8  received byte, valid only while cmdfifo_rxf=1.
REQ-006 cmdfifo_rd  out  1  one-cycle acknowledge of each consumed byte.
REQ-007 cmdfifo_txe  in  1  high = transmitter accepts a byte this cycle.
REQ-008 cmdfifo_wr  out  1  one-cycle write strobe to transmitter.
REQ-009 cmdfifo_dout  out  8  byte to transmit, stable while cmdfifo_wr=1.
REQ-010 reg_address  out  7  register address of current command.
REQ-011 reg_bytecnt  out  8  byte index within current command.
REQ-012 reg_datao  out  8  write data, valid with reg_write.
REQ-013 reg_datai  in  8  read data, valid one cycle after reg_read.
REQ-014 reg_read  out  1  one-cycle read strobe.
REQ-015 reg_write  out  1  one-cycle write strobe.
REQ-016 busy_o  out  1  high in any state except IDLE.
REQ-017 timeout_o  out  1  one-cycle pulse on timeout abort.

Function
REQ-018 Packet SHALL be: header byte {rw, addr[6:0]} (rw=1 read, 0 write), length byte N (0..255), then N data bytes for writes only.
REQ-019 FSM SHALL have states IDLE, GET_LEN, WR_DATA, RD_REQ, RD_CAPT, TX_WAIT, TX_HOLD.
REQ-020 IDLE: on cmdfifo_rxf latch addr and rw into registers, reg_address updates next cycle, go GET_LEN.
REQ-021 GET_LEN: on cmdfifo_rxf latch N, clear reg_bytecnt to 0; N=0 -> IDLE with no strobes and no TX bytes; else rw=0 -> WR_DATA, rw=1 -> RD_REQ.
REQ-022 cmdfifo_rd SHALL pulse in the cycle after every cmdfifo_rxf consumed in IDLE, GET_LEN or WR_DATA.
REQ-023 WR_DATA: each cmdfifo_rxf SHALL produce, next cycle, reg_write=1 for one cycle with reg_datao=byte and reg_bytecnt=index; reg_bytecnt increments after the strobe; after the N-th strobe go IDLE.
REQ-024 RD_REQ: assert reg_read one cycle with current reg_bytecnt, go RD_CAPT.
REQ-025 RD_CAPT: register reg_datai into cmdfifo_dout, go TX_WAIT (read latency reg_read to captured data = 1 cycle).
REQ-026 TX_WAIT: when cmdfifo_txe=1 assert cmdfifo_wr one cycle, go TX_HOLD; cmdfifo_wr SHALL never be high in consecutive cycles.
REQ-027 TX_HOLD: one cycle, no sampling of cmdfifo_txe; increment reg_bytecnt; if N bytes sent go IDLE else RD_REQ.
REQ-028 cmdfifo_rxf pulses in RD_REQ, RD_CAPT, TX_WAIT, TX_HOLD SHALL be ignored with no cmdfifo_rd.
REQ-029 Timeout counter SHALL clear on entering GET_LEN or WR_DATA and on each cmdfifo_rxf there; on reaching TIMEOUT-1 FSM goes IDLE, timeout_o pulses one cycle, no further strobes.
REQ-030 Read states SHALL have no timeout; TX_WAIT waits indefinitely for cmdfifo_txe.
REQ-031 reg_bytecnt SHALL be 8 bits, max index 254 (N=255), no wrap within a packet.

Reset
REQ-032 reset_i=0 SHALL asynchronously force IDLE and drive cmdfifo_rd, cmdfifo_wr, reg_read, reg_write, timeout_o, busy_o to 0 and cmdfifo_dout, reg_address, reg_bytecnt, reg_datao to 0.
REQ-033 Reset mid-packet SHALL discard the packet; first byte after release is treated as a header.

Verification
REQ-034 Write: rxf bytes 0x05,0x02,0xAA,0x55 -> reg_write twice, addr 0x05, (bytecnt 0, 0xAA) then (1, 0x55), four cmdfifo_rd pulses, busy_o low after.
REQ-035 Read: bytes 0x83,0x02, reg_datai 0x11 then 0x22, txe held 1 -> reg_read at addr 0x03 bytecnt 0,1; cmdfifo_wr with dout 0x11 then 0x22, never consecutive cycles.
REQ-036 Backpressure: read N=1 with txe=0 for 50 cycles -> no cmdfifo_wr until txe=1, then exactly one wr.
REQ-037 Timeout: TIMEOUT=16, send 0x05 only -> timeout_o pulse 16 cycles later, next 0x05,0x00 handled as new zero-length write with no strobes.
REQ-038 Zero length read 0x81,0x00 -> no reg_read, no cmdfifo_wr, return IDLE.
REQ-039 Reset mid-write after 0x05,0x03,0x01 -> all outputs 0 immediately; following 0x07,0x01,0x99 writes 0x99 to addr 0x07 bytecnt 0.

Source files
------------

// File: rtl/reg_cmd_engine.sv
// Byte-stream register command engine: decodes {rw,addr} / length / data packets
// into register strobes and streams read data back through the transmit FIFO.
module reg_cmd_engine #(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       cmdfifo_rxf,
  input  logic [7:0] cmdfifo_din,
  output logic       cmdfifo_rd,
  input  logic       cmdfifo_txe,
  output logic       cmdfifo_wr,
  output logic [7:0] cmdfifo_dout,
  output logic [6:0] reg_address,
  output logic [7:0] reg_bytecnt,
  output logic [7:0] reg_datao,
  input  logic [7:0] reg_datai,
  output logic       reg_read,
  output logic       reg_write,
  output logic       busy_o,
  output logic       timeout_o
);
  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // Fire on the cycle the counter would step onto TIMEOUT-1.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    IDLE, GET_LEN, WR_DATA, RD_REQ, RD_CAPT, TX_WAIT, TX_HOLD
  } state_e;

  state_e        state_q, state_d;
  logic          rw_q, rw_d;
  logic [7:0]    len_q, len_d;
  logic [CW-1:0] tmr_q, tmr_d;
  logic          rd_q, rd_d, wr_q, wr_d, read_q, read_d, write_q, write_d;
  logic          busy_q, busy_d, tout_q, tout_d;
  logic [7:0]    dout_q, dout_d, bytecnt_q, bytecnt_d, datao_q, datao_d;
  logic [6:0]    addr_q, addr_d;
  logic [7:0]    wr_idx, last_idx;
  logic          tmr_expired;

  always_comb begin
    // The byte index steps the cycle after each write strobe.
    wr_idx      = write_q ? bytecnt_q + 8'd1 : bytecnt_q;
    last_idx    = len_q - 8'd1;
    tmr_expired = (tmr_q == TO_LAST);
    state_d   = state_q;
    rw_d      = rw_q;
    len_d     = len_q;
    tmr_d     = '0;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    read_d    = 1'b0;
    write_d   = 1'b0;
    tout_d    = 1'b0;
    dout_d    = dout_q;
    bytecnt_d = wr_idx;
    datao_d   = datao_q;
    addr_d    = addr_q;
    unique case (state_q)
      IDLE: if (cmdfifo_rxf) begin
        rw_d    = cmdfifo_din[7];
        addr_d  = cmdfifo_din[6:0];
        rd_d    = 1'b1;
        state_d = GET_LEN;
      end
      GET_LEN: begin
        if (cmdfifo_rxf) begin
          rd_d      = 1'b1;
          len_d     = cmdfifo_din;
          bytecnt_d = '0;
          if (cmdfifo_din == 8'd0) state_d = IDLE;
          else if (rw_q) begin
            read_d  = 1'b1;
            state_d = RD_REQ;
          end else state_d = WR_DATA;
        end else if (tmr_expired) begin
          tout_d  = 1'b1;
          state_d = IDLE;
        end else tmr_d = tmr_q + CW'(1);
      end
      WR_DATA: begin
        if (cmdfifo_rxf) begin
          rd_d    = 1'b1;
          write_d = 1'b1;
          datao_d = cmdfifo_din;
          if (wr_idx == last_idx) state_d = IDLE;
        end else if (tmr_expired) begin
          tout_d  = 1'b1;
          state_d = IDLE;
        end else tmr_d = tmr_q + CW'(1);
      end
      RD_REQ:  state_d = RD_CAPT;
      RD_CAPT: begin
        dout_d  = reg_datai;
        state_d = TX_WAIT;
      end
      TX_WAIT: if (cmdfifo_txe) begin
        wr_d    = 1'b1;
        state_d = TX_HOLD;
      end
      TX_HOLD: begin
        bytecnt_d = bytecnt_q + 8'd1;
        if (bytecnt_q == last_idx) state_d = IDLE;
        else begin
          read_d  = 1'b1;
          state_d = RD_REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      rw_q      <= 1'b0;
      len_q     <= '0;
      tmr_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      busy_q    <= 1'b0;
      tout_q    <= 1'b0;
      dout_q    <= '0;
      bytecnt_q <= '0;
      datao_q   <= '0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      rw_q      <= rw_d;
      len_q     <= len_d;
      tmr_q     <= tmr_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      read_q    <= read_d;
      write_q   <= write_d;
      busy_q    <= busy_d;
      tout_q    <= tout_d;
      dout_q    <= dout_d;
      bytecnt_q <= bytecnt_d;
      datao_q   <= datao_d;
      addr_q    <= addr_d;
    end
  end

  assign cmdfifo_rd   = rd_q;
  assign cmdfifo_wr   = wr_q;
  assign cmdfifo_dout = dout_q;
  assign reg_address  = addr_q;
  assign reg_bytecnt  = bytecnt_q;
  assign reg_datao    = datao_q;
  assign reg_read     = read_q;
  assign reg_write    = write_q;
  assign busy_o       = busy_q;
  assign timeout_o    = tout_q;
endmodule

// File: tb/tb_reg_cmd_engine.sv
// Bench for reg_cmd_engine: packet-level reference model with per-cycle compare,
// directed packets with literal expectations, then randomized packet traffic.
module tb_reg_cmd_engine;
  localparam int TO = 16;
  localparam int M_HDR = 0, M_LEN = 1, M_DATA = 2, M_RD = 3;

  logic       clk_i = 1'b0, reset_i = 1'b0;
  logic       cmdfifo_rxf = 1'b0, cmdfifo_txe = 1'b0;
  logic [7:0] cmdfifo_din = 8'h00, reg_datai = 8'h00;
  logic       cmdfifo_rd, cmdfifo_wr, reg_read, reg_write, busy_o, timeout_o;
  logic [7:0] cmdfifo_dout, reg_bytecnt, reg_datao;
  logic [6:0] reg_address;

  reg_cmd_engine #(.TIMEOUT(TO)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .cmdfifo_rxf(cmdfifo_rxf), .cmdfifo_din(cmdfifo_din), .cmdfifo_rd(cmdfifo_rd),
    .cmdfifo_txe(cmdfifo_txe), .cmdfifo_wr(cmdfifo_wr), .cmdfifo_dout(cmdfifo_dout),
    .reg_address(reg_address), .reg_bytecnt(reg_bytecnt), .reg_datao(reg_datao),
    .reg_datai(reg_datai), .reg_read(reg_read), .reg_write(reg_write),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Reference model: packet progress plus absolute cycle numbers for read timing.
  int         m_mode = M_HDR, m_len = 0, m_idx = 0, m_quiet = 0;
  int         m_cap_at = -1, m_hold_at = -1;
  bit         m_rw = 0, m_txwait = 0;
  logic [6:0] m_addr = '0;
  logic [7:0] m_datao = '0, m_dout = '0, e_idx = '0;
  logic       e_rd = 0, e_wr = 0, e_read = 0, e_write = 0, e_tout = 0, e_busy = 0;

  task automatic model_reset();
    m_mode = M_HDR; m_len = 0; m_idx = 0; m_quiet = 0; m_cap_at = -1; m_hold_at = -1;
    m_rw = 0; m_txwait = 0; m_addr = '0; m_datao = '0; m_dout = '0; e_idx = '0;
    e_rd = 0; e_wr = 0; e_read = 0; e_write = 0; e_tout = 0; e_busy = 0;
  endtask

  task automatic silent_cycle();
    m_quiet++;
    if (m_quiet == TO - 1) begin
      e_tout = 1;
      m_mode = M_HDR;
    end
  endtask

  task automatic model_step(input int now);
    e_rd = 0; e_wr = 0; e_read = 0; e_write = 0; e_tout = 0;
    case (m_mode)
      M_HDR: if (cmdfifo_rxf) begin
        m_rw = cmdfifo_din[7]; m_addr = cmdfifo_din[6:0];
        e_rd = 1; m_quiet = 0; m_mode = M_LEN;
      end
      M_LEN: if (cmdfifo_rxf) begin
        e_rd = 1; m_len = int'(cmdfifo_din); m_idx = 0; m_quiet = 0;
        if (m_len == 0) m_mode = M_HDR;
        else if (m_rw) begin
          m_mode = M_RD; e_read = 1; e_idx = 8'd0;
          m_cap_at = now + 2; m_hold_at = -1; m_txwait = 0;
        end else m_mode = M_DATA;
      end else silent_cycle();
      M_DATA: if (cmdfifo_rxf) begin
        e_rd = 1; e_write = 1; e_idx = 8'(m_idx); m_datao = cmdfifo_din;
        m_idx++; m_quiet = 0;
        if (m_idx == m_len) m_mode = M_HDR;
      end else silent_cycle();
      default: begin
        if (now == m_hold_at) begin
          if (m_idx == m_len) m_mode = M_HDR;
          else begin
            e_read = 1; e_idx = 8'(m_idx); m_cap_at = now + 2;
          end
        end else if (now == m_cap_at) begin
          m_dout = reg_datai; m_txwait = 1;
        end else if (m_txwait && cmdfifo_txe) begin
          e_wr = 1; m_txwait = 0; m_hold_at = now + 1; m_idx++;
        end
      end
    endcase
    e_busy = (m_mode != M_HDR);
  endtask

  initial forever begin
    @(posedge clk_i or negedge reset_i);
    if (!reset_i) model_reset();
    else model_step(cyc);
  end

  // Read-data responder: data is valid only in the cycle after reg_read.
  logic [7:0] rsp_q[$];
  bit rsp_pend = 0;
  initial forever begin
    @(negedge clk_i);
    rsp_pend = reg_read;
    @(posedge clk_i);
    #1;
    if (rsp_pend && rsp_q.size() > 0) reg_datai = rsp_q.pop_front();
    else reg_datai = 8'($urandom);
  end

  bit txe_rand = 0, txe_val = 1;
  initial forever begin
    @(negedge clk_i);
    cmdfifo_txe = txe_rand ? 1'($urandom) : txe_val;
  end

  // Event logs used by the directed literal checks.
  int wlog[$], rlog[$], txlog[$], txcyc[$], tlog[$];
  int rdcnt = 0;

  initial forever begin
    logic [28:0] act, exp;
    @(negedge clk_i);
    act = {cmdfifo_rd, cmdfifo_wr, reg_read, reg_write, timeout_o, busy_o,
           reg_address, cmdfifo_dout, reg_datao};
    exp = {e_rd, e_wr, e_read, e_write, e_tout, e_busy, m_addr, m_dout, m_datao};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL outputs cyc=%0d got %h expected %h (rd,wr,read,write,tout,busy,addr,dout,datao)",
               cyc, act, exp);
    end
    if (e_read || e_write) begin
      checks++;
      if (reg_bytecnt !== e_idx) begin
        errors++;
        $display("FAIL bytecnt cyc=%0d got %0d expected %0d", cyc, reg_bytecnt, e_idx);
      end
    end
    if (reg_write) wlog.push_back(int'({reg_address, reg_bytecnt, reg_datao}));
    if (reg_read) rlog.push_back(int'({reg_address, reg_bytecnt}));
    if (cmdfifo_wr) begin txlog.push_back(int'(cmdfifo_dout)); txcyc.push_back(cyc); end
    if (timeout_o) tlog.push_back(cyc);
    if (cmdfifo_rd) rdcnt++;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    wlog.delete(); rlog.delete(); txlog.delete(); txcyc.delete(); tlog.delete(); rdcnt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_i);
      cmdfifo_rxf = 1'b0;
      cmdfifo_din = 8'($urandom);
    end
  endtask

  task automatic put(input logic [7:0] b);
    @(negedge clk_i);
    cmdfifo_rxf = 1'b1;
    cmdfifo_din = b;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (m_mode != M_HDR && n < budget) begin
      @(negedge clk_i);
      cmdfifo_rxf = (m_mode == M_RD) && ($urandom_range(0, 3) == 0);
      cmdfifo_din = 8'($urandom);
      n++;
    end
    checks++;
    if (m_mode != M_HDR) begin
      errors++;
      $display("FAIL wait_idle: still busy after %0d cycles, expected idle", budget);
    end
    idle(1);
  endtask

  function automatic int pick_gap();
    return ($urandom_range(0, 11) == 0) ? TO : $urandom_range(0, 2);
  endfunction

  initial begin
    int hc;
    logic [7:0] wd[255];
    idle(3);
    chk("reset_state", int'({cmdfifo_rd, cmdfifo_wr, reg_read, reg_write, timeout_o, busy_o,
                             reg_address, reg_bytecnt, reg_datao, cmdfifo_dout}), 0);
    reset_i = 1'b1;
    idle(2);

    // Two-byte write
    clr();
    put(8'h05); put(8'h02); put(8'hAA); put(8'h55); idle(6);
    chk("wr_count", wlog.size(), 2);
    chk("wr0", at(wlog, 0), 'h0500AA);
    chk("wr1", at(wlog, 1), 'h050155);
    chk("wr_rd_pulses", rdcnt, 4);
    chk("wr_busy_after", int'(busy_o), 0);

    // Two-byte read with transmitter always ready
    clr(); txe_val = 1;
    rsp_q.push_back(8'h11); rsp_q.push_back(8'h22);
    put(8'h83); put(8'h02); idle(1); wait_idle(200); idle(2);
    chk("rd_count", rlog.size(), 2);
    chk("rd0", at(rlog, 0), 'h0300);
    chk("rd1", at(rlog, 1), 'h0301);
    chk("tx0", at(txlog, 0), 'h11);
    chk("tx1", at(txlog, 1), 'h22);
    chk("tx_spacing", at(txcyc, 1) - at(txcyc, 0), 4);
    chk("rd_rd_pulses", rdcnt, 2);

    // Backpressure
    clr(); txe_val = 0; rsp_q.push_back(8'h3C);
    put(8'h8A); put(8'h01); idle(50);
    chk("bp_no_tx", txlog.size(), 0);
    chk("bp_busy", int'(busy_o), 1);
    txe_val = 1; idle(10);
    chk("bp_one_tx", txlog.size(), 1);
    chk("bp_tx_data", at(txlog, 0), 'h3C);
    chk("bp_idle", int'(busy_o), 0);

    // Inter-byte timeout, then a zero-length write
    clr();
    put(8'h05); hc = cyc; idle(20);
    chk("to_count", tlog.size(), 1);
    chk("to_delay", at(tlog, 0) - hc, 16);
    clr();
    put(8'h05); put(8'h00); idle(4);
    chk("zw_no_write", wlog.size(), 0);
    chk("zw_no_timeout", tlog.size(), 0);
    chk("zw_rd_pulses", rdcnt, 2);
    chk("zw_idle", int'(busy_o), 0);

    // Zero-length read
    clr();
    put(8'h81); put(8'h00); idle(4);
    chk("zr_no_read", rlog.size(), 0);
    chk("zr_no_tx", txlog.size(), 0);
    chk("zr_idle", int'(busy_o), 0);

    // Reset in the middle of a write packet
    clr();
    put(8'h05); put(8'h03); put(8'h01); idle(1);
    #2 reset_i = 1'b0;
    #1 chk("reset_async", int'({cmdfifo_rd, cmdfifo_wr, reg_read, reg_write, timeout_o, busy_o,
                                reg_address, reg_bytecnt, reg_datao, cmdfifo_dout}), 0);
    idle(2);
    reset_i = 1'b1;
    clr();
    put(8'h07); put(8'h01); put(8'h99); idle(4);
    chk("post_reset_count", wlog.size(), 1);
    chk("post_reset_wr", at(wlog, 0), 'h070099);

    // Maximum-length write, back to back
    clr();
    put(8'h12); put(8'hFF);
    for (int i = 0; i < 255; i++) begin
      wd[i] = 8'($urandom);
      put(wd[i]);
    end
    idle(4);
    chk("max_count", wlog.size(), 255);
    chk("max_first", at(wlog, 0), int'({7'h12, 8'd0, wd[0]}));
    chk("max_last", at(wlog, 254), int'({7'h12, 8'd254, wd[254]}));

    // Randomized packets against the model
    txe_rand = 1;
    for (int p = 0; p < 250; p++) begin
      logic [7:0] hdr;
      int n;
      hdr = 8'($urandom);
      n = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 40) : $urandom_range(0, 4);
      put(hdr);
      idle(pick_gap());
      put(8'(n));
      if (!hdr[7]) begin
        for (int i = 0; i < n; i++) begin
          idle(pick_gap());
          put(8'($urandom));
        end
      end
      idle(1);
      wait_idle(5000);
      idle($urandom_range(0, 3));
    end
    txe_rand = 0;
    idle(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
